// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, an output slot feeding IF/ID,
// and a one-deep pending buffer for responses that arrive while IF/ID is stalled.
// Optional build macro FETCH_NOP_BUBBLE_EN: an invalid slot presents addi x0,x0,0.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        out_valid,
  output logic [31:0] out_instruction,
  output logic [31:0] out_PC
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc;
  logic        slot_valid;
  logic [31:0] slot_instr;
  logic [31:0] slot_pc;
  logic        pend_valid;
  logic [31:0] pend_instr;
  logic [31:0] pend_pc;
  logic        accept;
  logic        consume;
  logic        slot_free;

  always_comb begin
    imem_req_valid = (state == S_REQ) && !reset;
    imem_req_addr  = pc;
    accept         = imem_req_valid && imem_req_ready;
    consume        = slot_valid && !stall_i;
    slot_free      = !slot_valid || consume;
  end

  // Redirect overrides every state action; an in-flight request must still be drained.
  always_comb begin
    state_n = state;
    if (redirect_valid) begin
      case (state)
        S_REQ:   state_n = accept ? S_DRAIN : S_REQ;
        S_WAIT:  state_n = imem_resp_valid ? S_REQ : S_DRAIN;
        S_HOLD:  state_n = S_REQ;
        S_DRAIN: state_n = imem_resp_valid ? S_REQ : S_DRAIN;
        default: state_n = S_REQ;
      endcase
    end else begin
      case (state)
        S_REQ:   if (accept) state_n = S_WAIT;
        S_WAIT:  if (imem_resp_valid) state_n = slot_free ? S_REQ : S_HOLD;
        S_HOLD:  if (consume) state_n = S_REQ;
        S_DRAIN: if (imem_resp_valid) state_n = S_REQ;
        default: state_n = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      slot_valid <= 1'b0;
      slot_instr <= '0;
      slot_pc    <= '0;
      pend_valid <= 1'b0;
      pend_instr <= '0;
      pend_pc    <= '0;
    end else begin
      state <= state_n;
      if (redirect_valid) begin
        pc         <= redirect_pc;
        slot_valid <= 1'b0;
        pend_valid <= 1'b0;
      end else begin
        if (consume) slot_valid <= 1'b0;
        case (state)
          S_WAIT: begin
            if (imem_resp_valid) begin
              pc <= pc + 32'd4;
              if (slot_free) begin
                slot_valid <= 1'b1;
                slot_instr <= imem_resp_data;
                slot_pc    <= pc;
              end else begin
                pend_valid <= 1'b1;
                pend_instr <= imem_resp_data;
                pend_pc    <= pc;
              end
            end
          end
          S_HOLD: begin
            if (consume) begin
              slot_valid <= pend_valid;
              slot_instr <= pend_instr;
              slot_pc    <= pend_pc;
              pend_valid <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    out_valid = slot_valid;
    out_PC    = slot_pc;
`ifdef FETCH_NOP_BUBBLE_EN
    out_instruction = slot_valid ? slot_instr : 32'h0000_0013;
`else
    out_instruction = slot_instr;
`endif
  end

endmodule
